// File: rtl/csi2_transmitter_if.sv
// CSI-2 transmitter handshake and lane bus.
// The master side issues packet requests and supplies payload; the slave side drives the PHY lanes.
interface csi2_transmitter_if #(
    parameter int NUM_LANES = 2
);
    logic                       packet_valid;
    logic                       packet_ready;
    logic [1:0]                 virtual_channel;
    logic [5:0]                 data_type;
    logic [15:0]                word_count;
    logic [NUM_LANES-1:0][7:0]  payload_data;
    logic                       payload_valid;
    logic                       payload_ready;
    logic [NUM_LANES-1:0][7:0]  lane_data;
    logic [NUM_LANES-1:0]       lane_enable;
    logic                       hs_request;
    logic                       underflow;

    modport master (
        output packet_valid, virtual_channel, data_type, word_count, payload_data, payload_valid,
        input  packet_ready, payload_ready, lane_data, lane_enable, hs_request, underflow
    );

    modport slave (
        input  packet_valid, virtual_channel, data_type, word_count, payload_data, payload_valid,
        output packet_ready, payload_ready, lane_data, lane_enable, hs_request, underflow
    );
endinterface

// File: rtl/csi2_transmitter.sv
// CSI-2 packet framer: request -> SOT, header(+ECC), payload, footer, EOT over NUM_LANES byte lanes.
// Latency: first header byte two cycles after acceptance; payload bytes go out in the cycle they are taken.
// Backpressure: none on the PHY side; payload starvation sends 0x00 and pulses underflow. Optional CRC: CSI2_TX_CRC_EN.
module csi2_transmitter #(
    parameter int NUM_LANES = 2
) (
    input  logic              clock_p,
    input  logic              reset_n,
    csi2_transmitter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SOT, HEADER, PAYLOAD, FOOTER, EOT} state_t;

    state_t                     state;
    state_t                     state_d;
    logic [7:0]                 hdr_di;
    logic [15:0]                wc_q;
    logic [7:0]                 ecc_q;
    logic                       long_q;
    logic [16:0]                cnt;
    logic [16:0]                base_d;
    logic [16:0]                pay_end;
    logic [16:0]                total;
    logic                       live;
    logic                       rdy_q;
    logic                       hs_q;
    logic [NUM_LANES-1:0]       en_q, en_d;
    logic [NUM_LANES-1:0]       pay_mask, pay_d;
    logic [NUM_LANES-1:0]       flo_mask, flo_d;
    logic [NUM_LANES-1:0]       fhi_mask, fhi_d;
    logic [NUM_LANES-1:0][7:0]  hdr_lane, hdr_d;
    logic [NUM_LANES-1:0][7:0]  pay_byte;
    logic [NUM_LANES-1:0][7:0]  lane_mux;
    logic [15:0]                crc_cur;

    function automatic logic [7:0] ecc_calc(input logic [23:0] d);
        ecc_calc = {2'b00,
                    ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                    ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    assign pay_end = 17'd4 + {1'b0, wc_q};
    assign total   = long_q ? pay_end + 17'd2 : 17'd4;
    assign base_d  = (state == SOT) ? 17'd0 : cnt + 17'(NUM_LANES);
    assign live    = (state == SOT) || (state == HEADER) || (state == PAYLOAD) || (state == FOOTER);

    always_comb begin
        if (base_d >= total)        state_d = EOT;
        else if (base_d < 17'd4)    state_d = HEADER;
        else if (base_d < pay_end)  state_d = PAYLOAD;
        else                        state_d = FOOTER;
    end

    // Classify every lane of the upcoming cycle by its stream byte index.
    always_comb begin
        logic [16:0] b;
        b     = '0;
        en_d  = '0;
        pay_d = '0;
        flo_d = '0;
        fhi_d = '0;
        hdr_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            b        = base_d + 17'(l);
            en_d[l]  = live && (b < total);
            pay_d[l] = live && long_q && (b >= 17'd4) && (b < pay_end);
            flo_d[l] = live && long_q && (b == pay_end);
            fhi_d[l] = live && long_q && (b == pay_end + 17'd1);
            if (live && (b < 17'd4)) begin
                case (b[1:0])
                    2'd0:    hdr_d[l] = hdr_di;
                    2'd1:    hdr_d[l] = wc_q[7:0];
                    2'd2:    hdr_d[l] = wc_q[15:8];
                    default: hdr_d[l] = ecc_q;
                endcase
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++)
            pay_byte[l] = bus.payload_valid ? bus.payload_data[l] : 8'h00;
    end

`ifdef CSI2_TX_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    // Footer lanes sharing the last payload cycle need the bytes of that same cycle folded in.
    always_comb begin
        crc_cur = crc_q;
        for (int l = 0; l < NUM_LANES; l++)
            if (pay_mask[l]) crc_cur = crc_byte(crc_cur, pay_byte[l]);
    end

    always_ff @(posedge clock_p) begin
        if (!reset_n)           crc_q <= 16'hFFFF;
        else if (state == SOT)  crc_q <= 16'hFFFF;
        else if (|pay_mask)     crc_q <= crc_cur;
    end
`else
    assign crc_cur = 16'h0000;
`endif

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (pay_mask[l])      lane_mux[l] = pay_byte[l];
            else if (flo_mask[l]) lane_mux[l] = crc_cur[7:0];
            else if (fhi_mask[l]) lane_mux[l] = crc_cur[15:8];
            else                  lane_mux[l] = hdr_lane[l];
        end
    end

    always_ff @(posedge clock_p) begin
        if (!reset_n) begin
            state    <= IDLE;
            rdy_q    <= 1'b0;
            hs_q     <= 1'b0;
            en_q     <= '0;
            pay_mask <= '0;
            flo_mask <= '0;
            fhi_mask <= '0;
            hdr_lane <= '0;
            cnt      <= '0;
            hdr_di   <= '0;
            wc_q     <= '0;
            ecc_q    <= '0;
            long_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            pay_mask <= pay_d;
            flo_mask <= flo_d;
            fhi_mask <= fhi_d;
            hdr_lane <= hdr_d;
            case (state)
                IDLE: begin
                    if (bus.packet_valid && rdy_q) begin
                        hdr_di <= {bus.virtual_channel, bus.data_type};
                        wc_q   <= bus.word_count;
                        ecc_q  <= ecc_calc({bus.word_count, bus.virtual_channel, bus.data_type});
                        long_q <= (bus.data_type > 6'h0F);
                        rdy_q  <= 1'b0;
                        hs_q   <= 1'b1;
                        state  <= SOT;
                    end else begin
                        rdy_q  <= 1'b1;
                    end
                end
                SOT: begin
                    cnt   <= 17'd0;
                    state <= HEADER;
                end
                HEADER, PAYLOAD, FOOTER: begin
                    cnt   <= base_d;
                    state <= state_d;
                end
                EOT: begin
                    hs_q  <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.packet_ready  = rdy_q;
    assign bus.hs_request    = hs_q;
    assign bus.lane_enable   = en_q;
    assign bus.lane_data     = lane_mux;
    assign bus.payload_ready = |pay_mask;
    assign bus.underflow     = (|pay_mask) & ~bus.payload_valid;
endmodule

// File: tb/tb_csi2_transmitter.sv
// Self-checking bench for csi2_transmitter: 2-lane and 4-lane instances against a byte-stream model.
// Honours CSI2_TX_CRC_EN in its footer model.
`timescale 1ns/1ps
module tb_csi2_transmitter;
    logic clock_p = 1'b0;
    always #5 clock_p = ~clock_p;

    logic            reset_n;
    logic            sel;
    logic            pkt_valid;
    logic [1:0]      vc_in;
    logic [5:0]      dt_in;
    logic [15:0]     wc_in;
    logic [3:0][7:0] pay_in;
    logic            pay_valid;

    csi2_transmitter_if #(.NUM_LANES(2)) bus2 ();
    csi2_transmitter_if #(.NUM_LANES(4)) bus4 ();

    csi2_transmitter #(.NUM_LANES(2)) dut2 (.clock_p(clock_p), .reset_n(reset_n), .bus(bus2.slave));
    csi2_transmitter #(.NUM_LANES(4)) dut4 (.clock_p(clock_p), .reset_n(reset_n), .bus(bus4.slave));

    assign bus2.packet_valid    = pkt_valid & ~sel;
    assign bus4.packet_valid    = pkt_valid & sel;
    assign bus2.virtual_channel = vc_in;
    assign bus4.virtual_channel = vc_in;
    assign bus2.data_type       = dt_in;
    assign bus4.data_type       = dt_in;
    assign bus2.word_count      = wc_in;
    assign bus4.word_count      = wc_in;
    assign bus2.payload_data    = pay_in[1:0];
    assign bus4.payload_data    = pay_in;
    assign bus2.payload_valid   = pay_valid;
    assign bus4.payload_valid   = pay_valid;

    logic [3:0][7:0] o_lane;
    logic [3:0]      o_en;
    logic            o_hs, o_prdy, o_pay_rdy, o_uf;

    always_comb begin
        if (sel) begin
            o_lane = bus4.lane_data;   o_en = bus4.lane_enable;
            o_hs = bus4.hs_request;    o_prdy = bus4.packet_ready;
            o_pay_rdy = bus4.payload_ready; o_uf = bus4.underflow;
        end else begin
            o_lane = {16'h0000, bus2.lane_data}; o_en = {2'b00, bus2.lane_enable};
            o_hs = bus2.hs_request;    o_prdy = bus2.packet_ready;
            o_pay_rdy = bus2.payload_ready; o_uf = bus2.underflow;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Syndrome contribution of each of the 24 header bits.
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    function automatic logic [7:0] ecc_ref(input logic [23:0] d);
        logic [5:0] e = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return {2'b00, e};
    endfunction

    function automatic logic [15:0] crc_ref(input logic [7:0] q [$]);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (q[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ q[i][k];
                c  = c >> 1;
                if (fb) c ^= 16'h8408;
            end
        end
        return c;
    endfunction

    logic [7:0] pay_src [$];

    // Called at a negedge with the chosen DUT idle; returns at a negedge.
    task automatic run_packet(input logic s, input logic [1:0] vc, input logic [5:0] dt,
                              input logic [15:0] wc, input int starve_d, input int reset_d,
                              input bit preset, input int ftr_force);
        int n, total, nd, cyc, b;
        logic is_long, pr;
        logic [15:0] crc;
        logic [7:0] stream [$];
        logic [7:0] pays [$];
        logic [3:0] exp_en;
        logic [3:0][7:0] exp_lane;

        n       = s ? 4 : 2;
        is_long = dt > 6'h0F;
        total   = is_long ? 4 + int'(wc) + 2 : 4;
        nd      = (total + n - 1) / n;
        if (!preset) begin
            pay_src = {};
            if (is_long) for (int i = 0; i < int'(wc); i++) pay_src.push_back(8'($urandom));
        end
        stream = {};
        stream.push_back({vc, dt});
        stream.push_back(wc[7:0]);
        stream.push_back(wc[15:8]);
        stream.push_back(ecc_ref({wc, vc, dt}));
        if (is_long) begin
            pays = {};
            for (int i = 0; i < int'(wc); i++)
                pays.push_back(((4 + i) / n == starve_d) ? 8'h00 : pay_src[i]);
            foreach (pays[i]) stream.push_back(pays[i]);
`ifdef CSI2_TX_CRC_EN
            crc = crc_ref(pays);
`else
            crc = 16'h0000;
`endif
            if (ftr_force >= 0) crc = 16'(ftr_force);
            stream.push_back(crc[7:0]);
            stream.push_back(crc[15:8]);
        end

        sel = s;
        cyc = 0;
        while (o_prdy !== 1'b1 && cyc < 20) begin
            @(negedge clock_p);
            cyc++;
        end
        chk("ready_before_req", o_prdy, 1'b1);
        pkt_valid = 1'b1; vc_in = vc; dt_in = dt; wc_in = wc;
        @(posedge clock_p); #1;
        pkt_valid = 1'b0; vc_in = 2'($urandom); dt_in = 6'($urandom); wc_in = 16'($urandom);
        @(negedge clock_p);
        chk("sot", {o_hs, o_en, o_prdy, o_pay_rdy, o_uf, o_lane}, {1'b1, 4'h0, 3'b000, 32'h0});

        for (int d = 0; d < nd; d++) begin
            @(posedge clock_p); #1;
            if (d == reset_d) reset_n = 1'b0;
            pay_valid = (d != starve_d);
            for (int l = 0; l < 4; l++) begin
                b = d * n + l;
                pay_in[l] = (l < n && is_long && b >= 4 && b < 4 + int'(wc)) ? pay_src[b - 4] : 8'($urandom);
            end
            @(negedge clock_p);
            exp_en = '0; exp_lane = '0; pr = 1'b0;
            for (int l = 0; l < n; l++) begin
                b = d * n + l;
                if (b < total) begin
                    exp_en[l]   = 1'b1;
                    exp_lane[l] = stream[b];
                end
                if (is_long && b >= 4 && b < 4 + int'(wc)) pr = 1'b1;
            end
            chk("lane_enable", o_en, exp_en);
            chk("lane_data", o_lane, exp_lane);
            chk("hs_in_burst", o_hs, 1'b1);
            chk("payload_ready", o_pay_rdy, pr);
            chk("underflow", o_uf, pr && (d == starve_d));
            if (d == reset_d) begin
                @(negedge clock_p);
                chk("reset_outputs", {o_lane, o_en, o_hs, o_prdy, o_pay_rdy, o_uf}, 64'h0);
                reset_n   = 1'b1;
                pay_valid = 1'b1;
                @(negedge clock_p);
                chk("ready_after_reset", {o_prdy, o_hs, o_en}, {1'b1, 1'b0, 4'h0});
                repeat (nd + 2) @(negedge clock_p);
                chk("no_resume", {o_hs, o_en, o_lane}, 64'h0);
                return;
            end
        end

        @(posedge clock_p); #1;
        pay_valid = 1'b1;
        @(negedge clock_p);
        chk("eot", {o_hs, o_en, o_prdy, o_pay_rdy, o_uf, o_lane}, {1'b1, 4'h0, 3'b000, 32'h0});
        @(negedge clock_p);
        chk("idle_after_eot", {o_hs, o_prdy, o_en}, {1'b0, 1'b1, 4'h0});
    endtask

    initial begin
        logic [7:0] vec [24];
        logic [5:0] rdt;
        logic [15:0] rwc;
        int rstarve;

        reset_n = 1'b0; sel = 1'b0; pkt_valid = 1'b0;
        vc_in = '0; dt_in = '0; wc_in = '0; pay_in = '0; pay_valid = 1'b1;
        repeat (3) @(negedge clock_p);
        chk("reset_state_2", {bus2.lane_data, bus2.lane_enable, bus2.hs_request, bus2.packet_ready,
                              bus2.payload_ready, bus2.underflow}, 64'h0);
        chk("reset_state_4", {bus4.lane_data, bus4.lane_enable, bus4.hs_request, bus4.packet_ready,
                              bus4.payload_ready, bus4.underflow}, 64'h0);
        reset_n = 1'b1;
        @(negedge clock_p);
        chk("ready_release_2", bus2.packet_ready, 1'b1);
        chk("ready_release_4", bus4.packet_ready, 1'b1);

        // All-zero short packet on two lanes.
        run_packet(1'b0, 2'd0, 6'h00, 16'h0000, -1, -1, 1'b0, -1);

        // Reference payload with its known footer.
        vec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        pay_src = {};
        foreach (vec[i]) pay_src.push_back(vec[i]);
`ifdef CSI2_TX_CRC_EN
        run_packet(1'b0, 2'd0, 6'h2A, 16'd24, -1, -1, 1'b1, 16'h00F0);
`else
        run_packet(1'b0, 2'd0, 6'h2A, 16'd24, -1, -1, 1'b1, 16'h0000);
`endif

        // Footer split across the last payload cycle on four lanes.
        run_packet(1'b1, 2'd1, 6'h2A, 16'd3, -1, -1, 1'b0, -1);
        // Payload starvation for one cycle, two and four lanes.
        run_packet(1'b0, 2'd2, 6'h2A, 16'd10, 3, -1, 1'b0, -1);
        run_packet(1'b1, 2'd3, 6'h24, 16'd13, 2, -1, 1'b0, -1);
        // Reset in the third payload cycle.
        run_packet(1'b0, 2'd0, 6'h2A, 16'd16, -1, 4, 1'b0, -1);
        // Zero-length long packet.
        run_packet(1'b1, 2'd0, 6'h2B, 16'd0, -1, -1, 1'b0, -1);
        // Short packet with nonzero data exercises the ECC.
        run_packet(1'b1, 2'd2, 6'h01, 16'hA5C3, -1, -1, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            rdt     = 6'($urandom);
            rwc     = (rdt > 6'h0F) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            rstarve = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_packet(1'($urandom), 2'($urandom), rdt, rwc, rstarve, -1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
